// File: rtl/postprocessor_pkg.sv
// Shared widths, side-pipeline tag type and the output clamp for the requant stage.
package postprocessor_pkg;
  localparam int TOUT      = 4;
  localparam int ACC_DW    = 32;
  localparam int BIAS_DW   = 16;
  localparam int SCALE_DW  = 16;
  localparam int W_SHIFT   = 5;
  localparam int W_DATA    = 8;
  localparam int OUT_DW    = W_DATA;
  localparam int OFM_DW    = TOUT * OUT_DW;
  localparam int W_SIZE    = 8;
  localparam int W_CHANNEL = 8;
  localparam int OFM_AW    = 16;

  localparam int S1_DW = ACC_DW + 1;
  localparam int S2_DW = S1_DW + SCALE_DW + 1;

  typedef struct packed {
    logic                 vld;
    logic                 last;
    logic [W_SIZE-1:0]    row;
    logic [W_SIZE-1:0]    col;
    logic [W_CHANNEL-1:0] chn;
    logic [OFM_AW-1:0]    addr;
  } pp_tag_t;

  // ReLU then saturate to 8 bits; r carries one guard bit above the product width.
  function automatic logic [OUT_DW-1:0] relu_sat(input logic signed [S2_DW:0] r);
    if (r[S2_DW])
      return '0;
    else if (|r[S2_DW-1:OUT_DW])
      return '1;
    else
      return r[OUT_DW-1:0];
  endfunction
endpackage

// File: rtl/postprocessor_if.sv
// Accumulator-in / pp-out beat bus of the postprocessor.
interface postprocessor_if;
  import postprocessor_pkg::*;

  logic                      acc_vld;
  logic [TOUT*ACC_DW-1:0]    acc_data;
  logic [TOUT*BIAS_DW-1:0]   bias_data;
  logic                      o_pp_data_vld;
  logic [OFM_DW-1:0]         o_pp_data;
  logic [W_SIZE-1:0]         o_pp_row;
  logic [W_SIZE-1:0]         o_pp_col;
  logic [W_CHANNEL-1:0]      o_pp_chn_out;
  logic [OFM_AW-1:0]         o_pp_addr;
  logic                      o_pp_done;

  modport master (
    output acc_vld, acc_data, bias_data,
    input  o_pp_data_vld, o_pp_data, o_pp_row, o_pp_col, o_pp_chn_out, o_pp_addr, o_pp_done
  );

  modport slave (
    input  acc_vld, acc_data, bias_data,
    output o_pp_data_vld, o_pp_data, o_pp_row, o_pp_col, o_pp_chn_out, o_pp_addr, o_pp_done
  );
endinterface

// File: rtl/pp_requant_lane.sv
// One requant lane: bias add, scale multiply, rounding shift + ReLU/saturate, one register each.
module pp_requant_lane
  import postprocessor_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [ACC_DW-1:0]   acc,
  input  logic signed [BIAS_DW-1:0]  bias,
  input  logic [SCALE_DW-1:0]        scale,
  input  logic [W_SHIFT-1:0]         shift,
  input  logic                       vld_s2,
  output logic [OUT_DW-1:0]          out
);
  logic signed [S1_DW-1:0] s1_q;
  logic signed [S2_DW-1:0] s2_q;
  logic [S2_DW-1:0]        s1_ext;
  logic [S2_DW-1:0]        scale_ext;
  logic [S2_DW:0]          rnd;
  logic signed [S2_DW:0]   sum;
  logic signed [S2_DW:0]   r;

  always_comb begin
    s1_ext    = {{(S2_DW-S1_DW){s1_q[S1_DW-1]}}, s1_q};
    scale_ext = {{(S2_DW-SCALE_DW){1'b0}}, scale};
    rnd       = '0;
    if (shift != '0)
      rnd = (S2_DW+1)'(1) << (shift - W_SHIFT'(1));
    sum = $signed({s2_q[S2_DW-1], s2_q}) + $signed(rnd);
    r   = sum >>> shift;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      out  <= '0;
    end else begin
      s1_q <= $signed({acc[ACC_DW-1], acc}) +
              $signed({{(S1_DW-BIAS_DW){bias[BIAS_DW-1]}}, bias});
      s2_q <= $signed(s1_ext) * $signed(scale_ext);
      out  <= vld_s2 ? relu_sat(r) : '0;
    end
  end
endmodule

// File: rtl/postprocessor.sv
// Requantization stage: position/address counters, tag side pipeline and Tout requant lanes.
module postprocessor
  import postprocessor_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [W_SIZE-1:0]     q_width,
  input  logic [W_SIZE-1:0]     q_height,
  input  logic [W_CHANNEL-1:0]  q_channel_out,
  input  logic [SCALE_DW-1:0]   q_scale,
  input  logic [W_SHIFT-1:0]    q_shift,
  input  logic                  q_start,
  postprocessor_if.slave        bus
);
  logic [W_SIZE-1:0]    col_q, row_q;
  logic [W_CHANNEL-1:0] chn_q;
  logic [OFM_AW-1:0]    base_q;

  logic [W_SIZE-1:0]    cur_col, cur_row;
  logic [W_CHANNEL-1:0] cur_chn;
  logic [OFM_AW-1:0]    cur_addr;
  logic                 col_end, row_end, chn_end;
  pp_tag_t              tag_in, tag_s1, tag_s2, tag_s3;

  // q_start acts on the same beat it coincides with, so the current view already sees zeros.
  always_comb begin
    cur_col  = q_start ? '0 : col_q;
    cur_row  = q_start ? '0 : row_q;
    cur_chn  = q_start ? '0 : chn_q;
    cur_addr = (cur_col == '0 && cur_row == '0) ? OFM_AW'(cur_chn) : base_q;
    col_end  = (cur_col == q_width - W_SIZE'(1));
    row_end  = (cur_row == q_height - W_SIZE'(1));
    chn_end  = (cur_chn == q_channel_out - W_CHANNEL'(1));
    tag_in      = '0;
    tag_in.vld  = bus.acc_vld;
    tag_in.last = bus.acc_vld & col_end & row_end & chn_end;
    if (bus.acc_vld) begin
      tag_in.row  = cur_row;
      tag_in.col  = cur_col;
      tag_in.chn  = cur_chn;
      tag_in.addr = cur_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      chn_q  <= '0;
      base_q <= '0;
    end else if (bus.acc_vld) begin
      col_q  <= col_end ? '0 : cur_col + W_SIZE'(1);
      base_q <= cur_addr + OFM_AW'(q_channel_out);
      if (col_end) begin
        row_q <= row_end ? '0 : cur_row + W_SIZE'(1);
        if (row_end)
          chn_q <= chn_end ? '0 : cur_chn + W_CHANNEL'(1);
        else
          chn_q <= cur_chn;
      end else begin
        row_q <= cur_row;
        chn_q <= cur_chn;
      end
    end else if (q_start) begin
      col_q  <= '0;
      row_q  <= '0;
      chn_q  <= '0;
      base_q <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_s1 <= '0;
      tag_s2 <= '0;
      tag_s3 <= '0;
    end else begin
      tag_s1 <= tag_in;
      tag_s2 <= tag_s1;
      tag_s3 <= tag_s2.vld ? tag_s2 : '0;
    end
  end

  for (genvar i = 0; i < TOUT; i++) begin : g_lane
    pp_requant_lane u_lane (
      .clk    (clk),
      .rst    (rst),
      .acc    ($signed(bus.acc_data[i*ACC_DW +: ACC_DW])),
      .bias   ($signed(bus.bias_data[i*BIAS_DW +: BIAS_DW])),
      .scale  (q_scale),
      .shift  (q_shift),
      .vld_s2 (tag_s2.vld),
      .out    (bus.o_pp_data[i*OUT_DW +: OUT_DW])
    );
  end

  assign bus.o_pp_data_vld = tag_s3.vld;
  assign bus.o_pp_row      = tag_s3.row;
  assign bus.o_pp_col      = tag_s3.col;
  assign bus.o_pp_chn_out  = tag_s3.chn;
  assign bus.o_pp_addr     = tag_s3.addr;
  assign bus.o_pp_done     = tag_s3.last;
endmodule

// File: tb/tb_postprocessor.sv
// Scoreboard bench for postprocessor: directed beats push expectations, a negedge monitor checks.
module tb_postprocessor;
  import postprocessor_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [W_SIZE-1:0]    q_width = 8'd2;
  logic [W_SIZE-1:0]    q_height = 8'd2;
  logic [W_CHANNEL-1:0] q_channel_out = 8'd2;
  logic [SCALE_DW-1:0]  q_scale = 16'd1;
  logic [W_SHIFT-1:0]   q_shift = 5'd2;
  logic                 q_start = 1'b0;

  postprocessor_if pp_if();

  postprocessor dut (
    .clk           (clk),
    .rst           (rst),
    .q_width       (q_width),
    .q_height      (q_height),
    .q_channel_out (q_channel_out),
    .q_scale       (q_scale),
    .q_shift       (q_shift),
    .q_start       (q_start),
    .bus           (pp_if.slave)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic [7:0]  row, col, chn;
    logic [15:0] addr;
    logic        done;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int n_vec = 0;
  int n_err = 0;

  always @(negedge clk) begin
    if (!rst) begin
      n_vec++;
      if (pp_if.o_pp_data_vld) begin
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_beat cyc=%0d data=%h row=%0d col=%0d chn=%0d addr=%0d",
                   cyc, pp_if.o_pp_data, pp_if.o_pp_row, pp_if.o_pp_col, pp_if.o_pp_chn_out, pp_if.o_pp_addr);
        end else begin
          e = sb.pop_front();
          if (e.cyc != cyc || e.data != pp_if.o_pp_data || e.row != pp_if.o_pp_row ||
              e.col != pp_if.o_pp_col || e.chn != pp_if.o_pp_chn_out ||
              e.addr != pp_if.o_pp_addr || e.done != pp_if.o_pp_done) begin
            n_err++;
            $display("FAIL beat got cyc=%0d data=%h r=%0d c=%0d ch=%0d a=%0d d=%0b want cyc=%0d data=%h r=%0d c=%0d ch=%0d a=%0d d=%0b",
                     cyc, pp_if.o_pp_data, pp_if.o_pp_row, pp_if.o_pp_col, pp_if.o_pp_chn_out,
                     pp_if.o_pp_addr, pp_if.o_pp_done,
                     e.cyc, e.data, e.row, e.col, e.chn, e.addr, e.done);
          end
        end
      end else if (pp_if.o_pp_data != '0 || pp_if.o_pp_row != '0 || pp_if.o_pp_col != '0 ||
                   pp_if.o_pp_chn_out != '0 || pp_if.o_pp_addr != '0 || pp_if.o_pp_done) begin
        n_err++;
        $display("FAIL idle_nonzero cyc=%0d data=%h row=%0d col=%0d chn=%0d addr=%0d done=%0b want all 0",
                 cyc, pp_if.o_pp_data, pp_if.o_pp_row, pp_if.o_pp_col, pp_if.o_pp_chn_out,
                 pp_if.o_pp_addr, pp_if.o_pp_done);
      end
    end
  end

  function automatic logic [127:0] lanes(input int a, input int b, input int c, input int d);
    return {d, c, b, a};
  endfunction

  function automatic logic [63:0] blanes(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic start();
    q_start = 1'b1;
    step();
    q_start = 1'b0;
  endtask

  task automatic beat(input logic [127:0] acc, input logic [63:0] bias, input logic [31:0] edata,
                      input int er, input int ec, input int ech, input int ea,
                      input logic ed, input logic st);
    exp_t x;
    pp_if.acc_vld   = 1'b1;
    pp_if.acc_data  = acc;
    pp_if.bias_data = bias;
    q_start         = st;
    x.cyc  = cyc + 3;
    x.data = edata;
    x.row  = er[7:0];
    x.col  = ec[7:0];
    x.chn  = ech[7:0];
    x.addr = ea[15:0];
    x.done = ed;
    sb.push_back(x);
    step();
    pp_if.acc_vld = 1'b0;
    q_start       = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() > 0 && t < 50) begin
      step();
      t++;
    end
    n_vec++;
    if (sb.size() > 0) begin
      n_err++;
      $display("FAIL drain_timeout pending=%0d want 0", sb.size());
      sb.delete();
    end
    idle(2);
  endtask

  task automatic frame_beat(input int i, input logic ed);
    int addr_tab[8] = '{0, 2, 4, 6, 1, 3, 5, 7};
    beat(lanes(4*i, 4*i, 4*i, 4*i), '0, 32'h01010101 * i[7:0],
         (i / 2) % 2, i % 2, i / 4, addr_tab[i], ed, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [7:0] pat;
    int idx;
    pp_if.acc_vld   = 1'b0;
    pp_if.acc_data  = '0;
    pp_if.bias_data = '0;
    idle(3);
    n_vec++;
    if (pp_if.o_pp_data_vld || pp_if.o_pp_data != '0 || pp_if.o_pp_addr != '0 || pp_if.o_pp_done) begin
      n_err++;
      $display("FAIL reset_state vld=%0b data=%h addr=%0d done=%0b want all 0",
               pp_if.o_pp_data_vld, pp_if.o_pp_data, pp_if.o_pp_addr, pp_if.o_pp_done);
    end
    rst = 1'b0;
    idle(2);

    // saturation: (1024 + 2) >> 2 = 256 -> 255
    start();
    beat(lanes(1000, 1000, 1000, 1000), blanes(24, 24, 24, 24), 32'hFFFFFFFF, 0, 0, 0, 0, 1'b0, 1'b0);
    drain();

    // scale 3, shift 0; q_start coincides with the first beat
    q_scale = 16'd3;
    q_shift = 5'd0;
    beat(lanes(-50, 40, 100, 0), blanes(10, 2, -10, 5), 32'h0FFF7E00, 0, 0, 0, 0, 1'b0, 1'b1);
    beat(lanes(5, 5, 5, 5), '0, 32'h0F0F0F0F, 0, 1, 0, 2, 1'b0, 1'b0);
    drain();

    // scale 3, shift 1: 15->8, -9->0, 600->255, 300->150
    q_shift = 5'd1;
    start();
    beat(lanes(5, -3, 200, 100), '0, 32'h96FF0008, 0, 0, 0, 0, 1'b0, 1'b0);
    drain();

    // full 2x2x2 frame back-to-back, then wrap into the next frame without q_start
    q_scale = 16'd1;
    q_shift = 5'd2;
    start();
    for (int i = 0; i < 8; i++) frame_beat(i, i == 7);
    beat('0, '0, 32'h0, 0, 0, 0, 0, 1'b0, 1'b0);
    drain();

    // idle gaps in acc_vld
    start();
    pat = 8'b1100_1101;
    idx = 0;
    for (int k = 0; k < 8; k++) begin
      if (pat[k]) begin
        frame_beat(idx, 1'b0);
        idx++;
      end else begin
        idle(1);
      end
    end
    drain();

    // reset during beat 3 flushes everything in flight
    start();
    for (int i = 0; i < 3; i++) frame_beat(i, 1'b0);
    pp_if.acc_vld  = 1'b1;
    pp_if.acc_data = lanes(12, 12, 12, 12);
    rst = 1'b1;
    sb.delete();
    step();
    pp_if.acc_vld = 1'b0;
    n_vec++;
    if (pp_if.o_pp_data_vld || pp_if.o_pp_data != '0 || pp_if.o_pp_row != '0 ||
        pp_if.o_pp_col != '0 || pp_if.o_pp_addr != '0 || pp_if.o_pp_done) begin
      n_err++;
      $display("FAIL reset_flush vld=%0b data=%h row=%0d col=%0d addr=%0d want all 0",
               pp_if.o_pp_data_vld, pp_if.o_pp_data, pp_if.o_pp_row, pp_if.o_pp_col, pp_if.o_pp_addr);
    end
    idle(1);
    rst = 1'b0;
    idle(6);
    start();
    beat(lanes(8, 8, 8, 8), '0, 32'h02020202, 0, 0, 0, 0, 1'b0, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
